fetch_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/npc_calc.sv | 29 ++
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: next-PC opcodes, NOP encoding and fetch-stage types.
// The control decoder uses the same NPC_* constants.
package pipeline_pkg;

  localparam logic [4:0] NPC_PLUS4  = 5'b00000;
  localparam logic [4:0] NPC_BRANCH = 5'b00001;
  localparam logic [4:0] NPC_JUMP   = 5'b00010;
  localparam logic [4:0] NPC_JALR   = 5'b00100;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RST,
    FETCH,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational redirect detection and target computation for EX-stage control flow.
module npc_calc
  import pipeline_pkg::*;
(
  input  logic [4:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] pc_rel;
  logic [31:0] reg_rel;

  always_comb begin
    pc_rel   = ex_pc + ex_imm;
    reg_rel  = (ex_rs1 + ex_imm) & ~32'h1;
    redirect = |npc_op;
    // JALR wins over JUMP/BRANCH for malformed multi-hot opcodes; JUMP and
    // BRANCH share the PC-relative target, so their relative order is moot.
    if ((npc_op & NPC_JALR) != 5'b00000) begin
      target = word_align(reg_rel);
    end else begin
      target = word_align(pc_rel);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem req/ready handshake, IF/ID register
// and a one-entry skid buffer for fetches that land while ID is stalled.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [4:0]  NPCOp,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  localparam logic [31:0] RESET_ADDR = word_align(RESET_PC);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;      // next address to fetch
  logic [31:0]  addr_q, addr_d;  // address currently on the bus
  logic         req_q, req_d;
  if_id_t       id_q, id_d;
  if_id_t       skid_q, skid_d;

  logic        redirect;
  logic [31:0] target;
  logic        accept;

  npc_calc u_npc_calc (
    .npc_op   (NPCOp),
    .ex_pc    (ex_pc),
    .ex_imm   (ex_imm),
    .ex_rs1   (ex_rs1),
    .redirect (redirect),
    .target   (target)
  );

  assign accept = req_q & imem_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    id_d    = id_q;
    skid_d  = skid_q;

    if (redirect) begin
      pc_d         = target;
      id_d.valid   = 1'b0;
      id_d.instr   = NOP_INSTR;
      skid_d.valid = 1'b0;
      if (req_q && !imem_ready) begin
        // The handshake cannot be withdrawn: finish the old fetch, then drop it.
        state_d = DROP;
      end else begin
        state_d = FETCH;
        addr_d  = target;
        req_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        RST: begin
          state_d = FETCH;
          addr_d  = pc_q;
          req_d   = 1'b1;
        end

        FETCH: begin
          if (accept) begin
            pc_d   = pc_q + 32'd4;
            addr_d = pc_q + 32'd4;
          end
          if (stall) begin
            if (accept) begin
              skid_d = '{valid: 1'b1, pc: addr_q, instr: imem_rdata};
            end
            req_d = !(skid_q.valid || accept);
          end else begin
            // A held skid entry always drains ahead of any new fetch data;
            // req is low while it is full, so no accept can collide with it.
            if (skid_q.valid) begin
              id_d         = skid_q;
              skid_d.valid = 1'b0;
            end else if (accept) begin
              id_d = '{valid: 1'b1, pc: addr_q, instr: imem_rdata};
            end else begin
              id_d.valid = 1'b0;
            end
            req_d = 1'b1;
          end
        end

        DROP: begin
          if (!stall) begin
            id_d.valid = 1'b0;
          end
          if (accept) begin
            state_d = FETCH;
            addr_d  = pc_q;
            req_d   = 1'b1;
          end
        end

        default: begin
          state_d = RST;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= RST;
      pc_q    <= RESET_ADDR;
      addr_q  <= RESET_ADDR;
      req_q   <= 1'b0;
      id_q    <= '{valid: 1'b0, pc: RESET_ADDR, instr: NOP_INSTR};
      // NOTE: the skid payload is reset along with its valid bit; it is a
      // single register, not a memory array, so the cost is negligible.
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      id_q    <= id_d;
      skid_q  <= skid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = id_q.valid;
  assign id_pc     = id_q.pc;
  assign id_instr  = id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, branch/JALR redirects,
// stall with skid buffer, redirect during a pending fetch, and reset mid-stall.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [4:0]  NPCOp;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .NPCOp      (NPCOp),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_instr   (id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory model: word is a fixed function of its address.
  assign imem_rdata = mem_word(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(imem_req), 32'd0);
    check({tag, "_addr"},  imem_addr,     32'h0000_0100);
    check({tag, "_valid"}, 32'(id_valid), 32'd0);
    check({tag, "_idpc"},  id_pc,         32'h0000_0100);
    check({tag, "_instr"}, id_instr,      32'h0000_0013);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    NPCOp = 5'b00000; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    step(); step();
    check_reset_values("rst");

    // Reset release: cycle 0 has rst low.
    rst = 1'b0;
    step();
    check("c1_req",   32'(imem_req), 32'd1);
    check("c1_addr",  imem_addr,     32'h100);
    check("c1_valid", 32'(id_valid), 32'd0);
    step();
    check("c2_valid", 32'(id_valid), 32'd1);
    check("c2_idpc",  id_pc,         32'h100);
    check("c2_instr", id_instr,      mem_word(32'h100));
    check("c2_addr",  imem_addr,     32'h104);
    step();
    check("c3_addr",  imem_addr,     32'h108);
    check("c3_idpc",  id_pc,         32'h104);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("run_addr", imem_addr, 32'h108 + 32'(4 * i));
      check("run_idpc", id_pc,     32'h104 + 32'(4 * i));
    end

    // BRANCH 0x120 - 8 while 0x12C is being fetched.
    NPCOp = 5'b00001; ex_pc = 32'h120; ex_imm = -32'sd8;
    step();
    NPCOp = 5'b00000;
    check("br_addr",   imem_addr,     32'h118);
    check("br_bubble", 32'(id_valid), 32'd0);
    step();
    check("br_valid", 32'(id_valid), 32'd1);
    check("br_idpc",  id_pc,         32'h118);
    check("br_instr", id_instr,      mem_word(32'h118));
    check("br_next",  imem_addr,     32'h11C);

    // JALR: (0x203 + 4) & ~1 = 0x206, aligned to 0x204.
    NPCOp = 5'b00100; ex_pc = 32'h500; ex_rs1 = 32'h203; ex_imm = 32'd4;
    step();
    NPCOp = 5'b00000;
    check("jalr_addr",  imem_addr,     32'h204);
    check("jalr_bubble", 32'(id_valid), 32'd0);
    step();
    check("jalr_idpc", id_pc, 32'h204);

    // Multi-hot 00110: JALR beats JUMP -> 0x400 + 0x10.
    NPCOp = 5'b00110; ex_pc = 32'h300; ex_imm = 32'h10; ex_rs1 = 32'h400;
    step();
    NPCOp = 5'b00000;
    check("prio_addr", imem_addr, 32'h410);
    step();
    check("prio_idpc", id_pc, 32'h410);

    // Wrap-around: 0xFFFF_FFF0 + 0x16 = 0x06 -> 0x04.
    NPCOp = 5'b00001; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h16;
    step();
    NPCOp = 5'b00000;
    check("wrap_addr", imem_addr, 32'h4);
    step();
    check("wrap_idpc", id_pc, 32'h4);

    // Stall while the fetch of 0x40 completes.
    NPCOp = 5'b00010; ex_pc = 32'h30; ex_imm = 32'h8;
    step();
    NPCOp = 5'b00000;
    check("jmp38_addr", imem_addr, 32'h38);
    step();
    step();
    check("s0_addr", imem_addr, 32'h40);
    check("s0_idpc", id_pc,     32'h3C);
    stall = 1'b1;
    step();
    check("s1_req",   32'(imem_req), 32'd0);
    check("s1_addr",  imem_addr,     32'h44);
    check("s1_idpc",  id_pc,         32'h3C);
    check("s1_valid", 32'(id_valid), 32'd1);
    check("s1_instr", id_instr,      mem_word(32'h3C));
    step();
    check("s2_req",  32'(imem_req), 32'd0);
    check("s2_idpc", id_pc,         32'h3C);
    step();
    check("s3_req",  32'(imem_req), 32'd0);
    check("s3_idpc", id_pc,         32'h3C);
    stall = 1'b0;
    step();
    check("s4_idpc",  id_pc,         32'h40);
    check("s4_instr", id_instr,      mem_word(32'h40));
    check("s4_valid", 32'(id_valid), 32'd1);
    check("s4_req",   32'(imem_req), 32'd1);
    check("s4_addr",  imem_addr,     32'h44);
    step();
    check("s5_idpc",  id_pc,    32'h44);
    check("s5_instr", id_instr, mem_word(32'h44));

    // Redirect to 0x200 in the first wait cycle of a fetch at 0x80.
    NPCOp = 5'b00010; ex_pc = 32'h80; ex_imm = 32'h0;
    step();
    check("u1_addr", imem_addr, 32'h80);
    ex_pc = 32'h200; imem_ready = 1'b0;
    step();
    NPCOp = 5'b00000;
    check("u2_addr",  imem_addr,     32'h80);
    check("u2_req",   32'(imem_req), 32'd1);
    check("u2_valid", 32'(id_valid), 32'd0);
    step();
    check("u3_addr", imem_addr,     32'h80);
    check("u3_req",  32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    step();
    check("u4_addr",  imem_addr,     32'h200);
    check("u4_valid", 32'(id_valid), 32'd0);
    step();
    check("u5_idpc",  id_pc,    32'h200);
    check("u5_instr", id_instr, mem_word(32'h200));
    imem_ready = 1'b0;
    step();
    check("u6_bubble", 32'(id_valid), 32'd0);
    check("u6_addr",   imem_addr,     32'h204);
    imem_ready = 1'b1;
    step();
    check("u7_idpc",  id_pc,         32'h204);
    check("u7_valid", 32'(id_valid), 32'd1);

    // Pending request under stall, then skid fills, then reset.
    stall = 1'b1; imem_ready = 1'b0;
    step();
    check("v1_req",  32'(imem_req), 32'd1);
    check("v1_addr", imem_addr,     32'h208);
    check("v1_idpc", id_pc,         32'h204);
    imem_ready = 1'b1;
    step();
    check("v2_req",  32'(imem_req), 32'd0);
    check("v2_idpc", id_pc,         32'h204);
    rst = 1'b1;
    step();
    check_reset_values("mid");
    rst = 1'b0; stall = 1'b0;
    step();
    check("r1_req",  32'(imem_req), 32'd1);
    check("r1_addr", imem_addr,     32'h100);
    step();
    check("r2_idpc",  id_pc,         32'h100);
    check("r2_valid", 32'(id_valid), 32'd1);
    check("r2_instr", id_instr,      mem_word(32'h100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
